axi_cmd_arbiter: RTL
====================

# axi_cmd_arbiter

Shares the single AXI address channel (combined read/write, selected by `atype`) of the DDR master between a write requester (UART→packer→word-FIFO drain path) and a read requester (readback/check path). Arbitrates, registers and holds the command until `aready`, returns a one-cycle grant to the winner, and tracks outstanding writes and reads against a configurable limit. Sits between the requesters and the AXI master port, in the `axi_clk` domain.

## Interface
- ADDR_WIDTH, 32, address width of requests and `aaddr`
- MAX_OUTSTANDING, 4, max in-flight transactions per direction (1..2^CNT_WIDTH-1)
- CNT_WIDTH, 3, width of outstanding counters
- WR_ID, 8'h00, `aid` driven for writes
- RD_ID, 8'h01, `aid` driven for reads

- axi_clk  in  1  clock; all logic on rising edge
- rstn  in  1  asynchronous, active-low reset
- wr_req / rd_req  in  1  request; held with stable addr/len until grant
- wr_addr / rd_addr  in  ADDR_WIDTH  burst start address
- wr_len / rd_len  in  8  AXI burst length field (beats-1)
- wr_gnt / rd_gnt  out  1  one-cycle pulse: command accepted by slave
- aid  out  8  WR_ID or RD_ID of held command
- aaddr  out  ADDR_WIDTH  command address
- alen  out  8  command length
- atype  out  1  1=write, 0=read
- avalid  out  1  command valid
- aready  in  1  slave accepts command
- bvalid, bready  in  1  write-response handshake (observed only)
- rvalid, rready, rlast  in  1  read-data handshake (observed only)
- rresp  in  2  read response
- wr_outstanding / rd_outstanding  out  CNT_WIDTH  in-flight counts
- busy  out  1  state≠IDLE or any count nonzero
- rd_err  out  1  sticky: nonzero `rresp` on last read beat
- proto_err  out  1  sticky: completion seen with count 0

## Operation
- States IDLE, ISSUE, GRANT.
- Eligibility: wr_elig = wr_req && wr_outstanding < MAX_OUTSTANDING; rd_elig likewise.
- IDLE: if any eligible, choose winner (see Configuration), latch addr/len/type/id into output registers, avalid←1, →ISSUE. Else stay.
- ISSUE: hold all command outputs stable; on avalid&&aready: avalid←0, winner gnt←1, winner count +1, last_grant←winner, →GRANT. Requester dropping req while in ISSUE has no effect: command completes.
- GRANT: gnt pulse visible; no arbitration this cycle; gnt←0, →IDLE. Requester must deassert or change req/addr/len by the end of the GRANT cycle.
- Counters: write −1 on bvalid&&bready; read −1 on rvalid&&rready&&rlast. Increment and decrement on same edge → unchanged. Decrement at 0 → counter stays 0, proto_err←1.
- rd_err←1 on rvalid&&rready&&rlast&&rresp≠0. Sticky errors clear only on reset.
- Reset (any time, including mid-ISSUE): state IDLE, avalid 0, gnts 0, counts 0, errors 0, aid WR_ID, aaddr/alen/atype 0, last_grant = read (write wins first tie). In-flight bus transactions are abandoned.

## Timing
- req sampled at edge N (IDLE) → avalid high from N+1.
- aready high at cycle with avalid → gnt high and avalid low the next cycle; count updated at same edge.
- Back-to-back: minimum 3 cycles per command (IDLE, ISSUE, GRANT) with aready tied high.
- No combinational path from any input to any output; all outputs registered.
- Count at MAX_OUTSTANDING blocks that direction in IDLE only; a command already in ISSUE is not affected.

## Configuration
- AXI_ARB_RR_EN defined: round-robin; on simultaneous eligibility the direction not equal to last_grant wins.
- Undefined: fixed priority, write always wins over read; last_grant kept but unused.

## Test plan
- Single write: wr_req, addr 0x100, len 7, aready high → avalid 1 cycle later with aaddr 0x100, alen 7, atype 1, aid 0x00; wr_gnt one cycle; wr_outstanding=1; bvalid&&bready → 0.
- Backpressure: aready low 5 cycles → aaddr/alen/atype/avalid stable all 5, gnt only after aready; wr_req dropped mid-ISSUE still issues.
- Contention: wr_req and rd_req held continuously → with macro, alternating W,R,W,R (write first); without macro, writes only until wr_outstanding=4, then reads.
- Limit: 4 writes issued, no bvalid → 5th wr_req never granted; one bvalid → issued within 3 cycles.
- Errors: read completion with rresp=2'b10 on rlast → rd_err=1, stays; bvalid with wr_outstanding=0 → proto_err=1, count stays 0; simultaneous issue and completion → count unchanged.
- Reset in ISSUE (aready low) → next cycle avalid 0, counts 0, state IDLE, busy 0; first grant after release is write on tie.

Source files
------------

// File: rtl/axi_cmd_arbiter.sv
// Shares one AXI address channel between a write and a read requester, holding each command until aready.
// Build option: define AXI_ARB_RR_EN for round-robin on ties; otherwise writes have fixed priority.
`timescale 1ns/1ps
module axi_cmd_arbiter #(
   parameter int          ADDR_WIDTH      = 32,
   parameter int          MAX_OUTSTANDING = 4,
   parameter int          CNT_WIDTH       = 3,
   parameter logic [7:0]  WR_ID           = 8'h00,
   parameter logic [7:0]  RD_ID           = 8'h01
) (
   input  logic                  axi_clk,
   input  logic                  rstn,
   input  logic                  wr_req,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [7:0]            wr_len,
   output logic                  wr_gnt,
   input  logic                  rd_req,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [7:0]            rd_len,
   output logic                  rd_gnt,
   output logic [7:0]            aid,
   output logic [ADDR_WIDTH-1:0] aaddr,
   output logic [7:0]            alen,
   output logic                  atype,
   output logic                  avalid,
   input  logic                  aready,
   input  logic                  bvalid,
   input  logic                  bready,
   input  logic                  rvalid,
   input  logic                  rready,
   input  logic                  rlast,
   input  logic [1:0]            rresp,
   output logic [CNT_WIDTH-1:0]  wr_outstanding,
   output logic [CNT_WIDTH-1:0]  rd_outstanding,
   output logic                  busy,
   output logic                  rd_err,
   output logic                  proto_err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      GRANT = 2'd2
   } state_t;

   localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_OUTSTANDING);

   state_t                 state_q;
   state_t                 state_nxt;
   logic                   last_wr_q;
   logic                   wr_elig;
   logic                   rd_elig;
   logic                   sel_wr;
   logic                   accept;
   logic                   wr_inc;
   logic                   rd_inc;
   logic                   wr_dec;
   logic                   rd_dec;
   logic [CNT_WIDTH-1:0]   wr_cnt_nxt;
   logic [CNT_WIDTH-1:0]   rd_cnt_nxt;
   logic                   perr_nxt;

   // Simultaneous +1/-1 cancels; a completion at zero saturates and is flagged separately.
   function automatic logic [CNT_WIDTH-1:0] cnt_update(input logic [CNT_WIDTH-1:0] cnt,
                                                       input logic inc, input logic dec);
      logic [CNT_WIDTH-1:0] res;
      res = cnt;
      if (inc && !dec)
         res = cnt + CNT_WIDTH'(1);
      else if (dec && !inc && (cnt != '0))
         res = cnt - CNT_WIDTH'(1);
      return res;
   endfunction

   assign wr_elig = wr_req && (wr_outstanding < MAX_CNT);
   assign rd_elig = rd_req && (rd_outstanding < MAX_CNT);
   assign accept  = (state_q == ISSUE) && avalid && aready;
   assign wr_inc  = accept && atype;
   assign rd_inc  = accept && !atype;
   assign wr_dec  = bvalid && bready;
   assign rd_dec  = rvalid && rready && rlast;

`ifdef AXI_ARB_RR_EN
   always_comb begin
      sel_wr = wr_elig;
      if (wr_elig && rd_elig)
         sel_wr = !last_wr_q;
   end
`else
   logic unused_last_grant;
   assign unused_last_grant = last_wr_q;
   always_comb begin
      sel_wr = wr_elig;
   end
`endif

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         IDLE:    if (wr_elig || rd_elig) state_nxt = ISSUE;
         ISSUE:   if (accept) state_nxt = GRANT;
         GRANT:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      wr_cnt_nxt = cnt_update(wr_outstanding, wr_inc, wr_dec);
      rd_cnt_nxt = cnt_update(rd_outstanding, rd_inc, rd_dec);
      perr_nxt   = (wr_dec && !wr_inc && (wr_outstanding == '0)) ||
                   (rd_dec && !rd_inc && (rd_outstanding == '0));
   end

   always_ff @(posedge axi_clk or negedge rstn) begin
      if (!rstn)
         state_q <= IDLE;
      else
         state_q <= state_nxt;
   end

   always_ff @(posedge axi_clk or negedge rstn) begin
      if (!rstn) begin
         aid            <= WR_ID;
         aaddr          <= '0;
         alen           <= '0;
         atype          <= 1'b0;
         avalid         <= 1'b0;
         wr_gnt         <= 1'b0;
         rd_gnt         <= 1'b0;
         last_wr_q      <= 1'b0;
         wr_outstanding <= '0;
         rd_outstanding <= '0;
         busy           <= 1'b0;
         rd_err         <= 1'b0;
         proto_err      <= 1'b0;
      end else begin
         wr_gnt <= 1'b0;
         rd_gnt <= 1'b0;
         if ((state_q == IDLE) && (wr_elig || rd_elig)) begin
            aid    <= sel_wr ? WR_ID : RD_ID;
            aaddr  <= sel_wr ? wr_addr : rd_addr;
            alen   <= sel_wr ? wr_len : rd_len;
            atype  <= sel_wr;
            avalid <= 1'b1;
         end
         if (accept) begin
            avalid    <= 1'b0;
            wr_gnt    <= atype;
            rd_gnt    <= !atype;
            last_wr_q <= atype;
         end
         wr_outstanding <= wr_cnt_nxt;
         rd_outstanding <= rd_cnt_nxt;
         busy           <= (state_nxt != IDLE) || (wr_cnt_nxt != '0) || (rd_cnt_nxt != '0);
         if (perr_nxt)
            proto_err <= 1'b1;
         if (rd_dec && (rresp != 2'b00))
            rd_err <= 1'b1;
      end
   end

endmodule
